amp_pwr_seq: RTL and testbench

- Power/shutdown sequencer for the class-D amplifier pair driven by spkr_drv.
- Holds the amps in shutdown until the EQ low-frequency queues are full (seq_low), then releases sht_dwn and waits a settle time. It unmutes on an audio sample boundary.
- Filters the asynchronous amp fault line Flt_n, shuts the amps down on a fault, retries after a cool-down, and locks out after repeated faults.
- Replaces ad-hoc sht_dwn/Flt_n glue at top level.

---
 rtl/amp_pwr_seq.sv | 157 +++++++++++++++
 tb/tb_amp_pwr_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/amp_pwr_seq.sv
// Power/shutdown sequencer for the class-D amplifier pair: powers up after the EQ
// queues fill, unmutes on a sample boundary, filters amp faults, retries and locks out.
module amp_pwr_seq #(
    parameter int SETTLE_CYC = 250000,
    parameter int RETRY_CYC  = 2500000,
    parameter int FLT_FILT   = 8,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seq_low,
    input  logic       vld,
    input  logic       Flt_n,
    input  logic       clr_lock,
    output logic       sht_dwn,
    output logic       mute,
    output logic [1:0] flt_cnt,
    output logic       locked_out
);

    localparam int TMAX = (SETTLE_CYC > RETRY_CYC) ? SETTLE_CYC : RETRY_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(FLT_FILT + 1);

    localparam logic [TW-1:0] SETTLE_END = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] RETRY_END  = TW'(RETRY_CYC - 1);
    localparam logic [FW-1:0] FILT_END   = FW'(FLT_FILT - 1);

    typedef enum logic [2:0] {
        WAIT_Q,
        PWR_UP,
        ARM,
        RUN,
        FAULT,
        LOCKOUT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [FW-1:0] filt_cnt;
    logic          flt_s1;
    logic          flt_s2;
    logic          filt_on;
    logic          flt_det;
    logic [1:0]    flt_cnt_nxt;
    logic          sht_dwn_nxt;
    logic          mute_nxt;
    logic          locked_out_nxt;

    // Flt_n is asynchronous to clk; idle-high reset value means no fault seen.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_s1 <= 1'b1;
            flt_s2 <= 1'b1;
        end else begin
            flt_s1 <= Flt_n;
            flt_s2 <= flt_s1;
        end
    end

    // The filter only runs while the amps are powered.
    assign filt_on = (state == PWR_UP) || (state == ARM) || (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= '0;
        end else if (!filt_on || flt_s2) begin
            filt_cnt <= '0;
        end else if (filt_cnt != FILT_END) begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign flt_det = filt_on && !flt_s2 && (filt_cnt == FILT_END);

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_Q: begin
                if (seq_low) state_nxt = PWR_UP;
            end
            PWR_UP: begin
                if (flt_det)                  state_nxt = FAULT;
                else if (!seq_low)            state_nxt = WAIT_Q;
                else if (timer == SETTLE_END) state_nxt = ARM;
            end
            ARM: begin
                if (flt_det)       state_nxt = FAULT;
                else if (!seq_low) state_nxt = WAIT_Q;
                else if (vld)      state_nxt = RUN;
            end
            RUN: begin
                if (flt_det)       state_nxt = FAULT;
                else if (!seq_low) state_nxt = ARM;
            end
            FAULT: begin
                if (timer == RETRY_END) begin
                    state_nxt = (int'(flt_cnt) >= MAX_RETRY) ? LOCKOUT : WAIT_Q;
                end
            end
            LOCKOUT: begin
                if (clr_lock) state_nxt = WAIT_Q;
            end
            default: state_nxt = WAIT_Q;
        endcase
    end

    // Timer restarts from zero on every state entry and only runs where it is used.
    always_comb begin
        timer_nxt = '0;
        if ((state_nxt == state) && ((state == PWR_UP) || (state == FAULT))) begin
            timer_nxt = timer + 1'b1;
        end
    end

    always_comb begin
        flt_cnt_nxt = flt_cnt;
        if ((state == LOCKOUT) && clr_lock) begin
            flt_cnt_nxt = 2'd0;
        end else if ((state_nxt == FAULT) && (state != FAULT) && (flt_cnt != 2'd3)) begin
            flt_cnt_nxt = flt_cnt + 2'd1;
        end
    end

    // Outputs are decoded from the next state so they change in the same
    // registered update as the transition, with no input-to-output path.
    always_comb begin
        sht_dwn_nxt    = (state_nxt == WAIT_Q) || (state_nxt == FAULT) || (state_nxt == LOCKOUT);
        mute_nxt       = (state_nxt != RUN);
        locked_out_nxt = (state_nxt == LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_Q;
            timer      <= '0;
            flt_cnt    <= 2'd0;
            sht_dwn    <= 1'b1;
            mute       <= 1'b1;
            locked_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            flt_cnt    <= flt_cnt_nxt;
            sht_dwn    <= sht_dwn_nxt;
            mute       <= mute_nxt;
            locked_out <= locked_out_nxt;
        end
    end

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Directed self-checking bench for amp_pwr_seq with shortened timing parameters.
module tb_amp_pwr_seq;

    localparam int SETTLE_CYC = 20;
    localparam int RETRY_CYC  = 50;
    localparam int FLT_FILT   = 4;
    localparam int MAX_RETRY  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       seq_low;
    logic       vld;
    logic       Flt_n;
    logic       clr_lock;
    logic       sht_dwn;
    logic       mute;
    logic [1:0] flt_cnt;
    logic       locked_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    amp_pwr_seq #(
        .SETTLE_CYC(SETTLE_CYC),
        .RETRY_CYC (RETRY_CYC),
        .FLT_FILT  (FLT_FILT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seq_low   (seq_low),
        .vld       (vld),
        .Flt_n     (Flt_n),
        .clr_lock  (clr_lock),
        .sht_dwn   (sht_dwn),
        .mute      (mute),
        .flt_cnt   (flt_cnt),
        .locked_out(locked_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_sht(input logic val, input int bound, input string tag, output int n);
        n = 0;
        while (sht_dwn !== val && n < bound) begin
            tick();
            n++;
        end
        if (sht_dwn !== val) check({tag, "_timeout"}, sht_dwn, val);
    endtask

    task automatic go_run(input string tag);
        int n;
        wait_sht(1'b0, 80, tag, n);
        vld = 1'b1;
        n   = 0;
        while (mute !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        vld = 1'b0;
        check(tag, mute, 0);
    endtask

    task automatic fault(input string tag, output int n);
        Flt_n = 1'b0;
        wait_sht(1'b1, 20, tag, n);
        Flt_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;

        rst      = 1'b1;
        seq_low  = 1'b0;
        vld      = 1'b0;
        Flt_n    = 1'b1;
        clr_lock = 1'b0;
        #1;
        check("rst_sht", sht_dwn, 1);
        check("rst_mute", mute, 1);
        check("rst_cnt", flt_cnt, 0);
        check("rst_lock", locked_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle with queues not full.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sht_dwn !== 1'b1 || mute !== 1'b1) bad++;
        end
        check("idle_shutdown", bad, 0);

        // Power-up, settle (a vld during settle must not unmute), then unmute on vld.
        seq_low = 1'b1;
        ticks(2);
        check("pwrup_sht", sht_dwn, 0);
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            vld = (i == 5);
            tick();
            if (mute !== 1'b1) bad++;
        end
        vld = 1'b0;
        check("settle_mute", bad, 0);
        ticks(3);
        check("mute_before_vld", mute, 1);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        check("unmute_on_vld", mute, 0);
        check("run_sht", sht_dwn, 0);

        // One-cycle queue dropout in RUN re-mutes without a power cycle.
        seq_low = 1'b0;
        tick();
        check("drop_mute", mute, 1);
        check("drop_sht", sht_dwn, 0);
        seq_low = 1'b1;
        tick();
        check("arm_hold_mute", mute, 1);
        check("arm_hold_sht", sht_dwn, 0);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        check("rearm_unmute", mute, 0);

        // Three-cycle fault glitch is filtered out.
        Flt_n = 1'b0;
        ticks(3);
        Flt_n = 1'b1;
        ticks(10);
        check("glitch_sht", sht_dwn, 0);
        check("glitch_mute", mute, 0);
        check("glitch_cnt", flt_cnt, 0);

        // Qualified fault from RUN, then retry after RETRY_CYC.
        fault("fault1", n);
        check("fault1_latency_ok", (n >= FLT_FILT) && (n <= FLT_FILT + 3), 1);
        check("fault1_mute", mute, 1);
        check("fault1_cnt", flt_cnt, 1);
        check("fault1_lock", locked_out, 0);
        wait_sht(1'b0, 100, "retry1", n);
        check("retry1_cycles", n, RETRY_CYC + 1);

        // clr_lock outside LOCKOUT is ignored.
        clr_lock = 1'b1;
        tick();
        clr_lock = 1'b0;
        check("clr_ignored_cnt", flt_cnt, 1);
        check("clr_ignored_sht", sht_dwn, 0);

        // Abort power-up at settle cycle 10.
        ticks(8);
        seq_low = 1'b0;
        tick();
        check("pwrup_abort_sht", sht_dwn, 1);
        check("pwrup_abort_mute", mute, 1);

        // Fault detected in the same cycle as vld in ARM wins.
        seq_low = 1'b1;
        ticks(SETTLE_CYC + 1);
        check("arm_ready_sht", sht_dwn, 0);
        check("arm_ready_mute", mute, 1);
        Flt_n = 1'b0;
        ticks(FLT_FILT + 1);
        vld = 1'b1;
        tick();
        vld   = 1'b0;
        Flt_n = 1'b1;
        check("flt_vs_vld_sht", sht_dwn, 1);
        check("flt_vs_vld_mute", mute, 1);
        check("flt_vs_vld_cnt", flt_cnt, 2);

        // Third fault leads to LOCKOUT at the end of the retry timer.
        wait_sht(1'b0, 100, "retry2", n);
        fault("fault3", n);
        check("fault3_cnt", flt_cnt, 3);
        check("fault3_lock", locked_out, 0);
        ticks(RETRY_CYC - 1);
        check("pre_lock", locked_out, 0);
        tick();
        check("lock_set", locked_out, 1);
        check("lock_sht", sht_dwn, 1);
        check("lock_cnt", flt_cnt, 3);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            vld   = (i % 3 == 0);
            Flt_n = (i % 7 != 0);
            tick();
            if (sht_dwn !== 1'b1 || mute !== 1'b1 || locked_out !== 1'b1) bad++;
        end
        vld   = 1'b0;
        Flt_n = 1'b1;
        check("lockout_hold", bad, 0);
        clr_lock = 1'b1;
        tick();
        clr_lock = 1'b0;
        check("clr_cnt", flt_cnt, 0);
        check("clr_lock_out", locked_out, 0);
        check("clr_wait_q_sht", sht_dwn, 1);
        tick();
        check("clr_repower", sht_dwn, 0);

        // Asynchronous reset mid-RUN.
        fault("fault4", n);
        check("fault4_cnt", flt_cnt, 1);
        go_run("run_pre_rst");
        check("run_pre_rst_cnt", flt_cnt, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_run_sht", sht_dwn, 1);
        check("rst_run_mute", mute, 1);
        check("rst_run_cnt", flt_cnt, 0);
        check("rst_run_lock", locked_out, 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-FAULT.
        go_run("run_again");
        fault("fault5", n);
        check("fault5_cnt", flt_cnt, 1);
        ticks(10);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_flt_sht", sht_dwn, 1);
        check("rst_flt_mute", mute, 1);
        check("rst_flt_cnt", flt_cnt, 0);
        check("rst_flt_lock", locked_out, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_repower", sht_dwn, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
